// File: rtl/bayer_pkg.sv
// Shared types for the Bayer demosaicer: CFA site colours, edge classes and FSM states.
// Colour encoding is the CFA phase index: bit1 = row parity, bit0 = column parity.
package bayer_pkg;

  localparam logic [1:0] CFA_RED     = 2'd0;
  localparam logic [1:0] CFA_GREEN_R = 2'd1;
  localparam logic [1:0] CFA_GREEN_B = 2'd2;
  localparam logic [1:0] CFA_BLUE    = 2'd3;

  typedef enum logic [1:0] {
    RED     = CFA_RED,
    GREEN_R = CFA_GREEN_R,
    GREEN_B = CFA_GREEN_B,
    BLUE    = CFA_BLUE
  } color_t;

  typedef enum logic [1:0] {LAT_INNER, LAT_WEST, LAT_EAST} lateral_t;
  typedef enum logic [1:0] {VERT_INNER, VERT_TOP, VERT_BOTTOM} vertical_t;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  function automatic color_t site_color(input logic [1:0] phase, input logic row_odd,
                                        input logic col_odd);
    return color_t'(phase ^ {row_odd, col_odd});
  endfunction

endpackage

// File: rtl/bayer_demosaic_stream_if.sv
// Raw-sample input stream and RGB output stream of the demosaicer, valid/ready on both.
// slave is the demosaicer side, master is the source/sink side.
interface bayer_demosaic_stream_if #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 40,
  parameter int IMG_H = 30
);
  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_red;
  logic [PIX_W-1:0] out_green;
  logic [PIX_W-1:0] out_blue;
  logic [X_W-1:0]   out_x;
  logic [Y_W-1:0]   out_y;
  logic             out_last;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_red, out_green, out_blue, out_x, out_y, out_last
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_red, out_green, out_blue, out_x, out_y, out_last
  );

endinterface

// File: rtl/bayer_window.sv
// Two line buffers plus a 3-column history giving an edge-mirrored 3x3 window around (cx, cy).
// Window is combinational on the current shift; counters advance on shift/emit only.
module bayer_window
  import bayer_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 40,
  parameter int IMG_H = 30,
  localparam int X_W = $clog2(IMG_W),
  localparam int Y_W = $clog2(IMG_H)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        shift,
  input  logic                        emit,
  input  logic [PIX_W-1:0]            pixel,
  output logic [2:0][2:0][PIX_W-1:0]  win,
  output logic [X_W-1:0]              cx,
  output logic [Y_W-1:0]              cy
);

  localparam logic [X_W-1:0] X_MAX = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(IMG_H - 1);

  // Column of three vertically adjacent samples: [0]=top, [1]=middle, [2]=bottom.
  typedef logic [2:0][PIX_W-1:0] col_t;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [X_W-1:0]   wx;
  col_t             col_a, col_b, new_col, west, east;
  col_t             w_f, c_f, e_f;
  lateral_t         lat;
  vertical_t        vert;

  function automatic col_t fold(input col_t c, input vertical_t v);
    col_t f;
    f = c;
    if (v == VERT_TOP)    f[0] = c[2];
    if (v == VERT_BOTTOM) f[2] = c[0];
    return f;
  endfunction

  assign new_col = {pixel, lb0[wx], lb1[wx]};

  always_comb begin
    lat = LAT_INNER;
    if (cx == '0)        lat = LAT_WEST;
    else if (cx == X_MAX) lat = LAT_EAST;
    vert = VERT_INNER;
    if (cy == '0)        vert = VERT_TOP;
    else if (cy == Y_MAX) vert = VERT_BOTTOM;
  end

  // col_a is always the centre column. At the right edge the incoming column
  // already belongs to the next row, so east folds back onto col_b.
  assign west = (lat == LAT_WEST) ? new_col : col_b;
  assign east = (lat == LAT_EAST) ? col_b : new_col;

  assign w_f = fold(west, vert);
  assign c_f = fold(col_a, vert);
  assign e_f = fold(east, vert);

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win[r][0] = w_f[r];
      win[r][1] = c_f[r];
      win[r][2] = e_f[r];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wx    <= '0;
      cx    <= '0;
      cy    <= '0;
      col_a <= '0;
      col_b <= '0;
    end else if (clear) begin
      wx <= '0;
      cx <= '0;
      cy <= '0;
    end else if (shift) begin
      col_b <= col_a;
      col_a <= new_col;
      wx    <= (wx == X_MAX) ? '0 : wx + 1'b1;
      if (emit) begin
        if (cx == X_MAX) begin
          cx <= '0;
          cy <= (cy == Y_MAX) ? '0 : cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shift) begin
      lb1[wx] <= lb0[wx];
      lb0[wx] <= pixel;
    end
  end

endmodule

// File: rtl/bayer_demosaic_stream.sv
// Streaming Bayer-to-RGB demosaicer: one cycle from enabling accept (or flush step) to out_valid.
// A stalled output holds every output register and drops in_ready.
module bayer_demosaic_stream
  import bayer_pkg::*;
#(
  parameter int         PIX_W     = 8,
  parameter int         IMG_W     = 40,
  parameter int         IMG_H     = 30,
  parameter logic [1:0] CFA_PHASE = 2'd0
) (
  input  logic                    clk,
  input  logic                    reset,
  bayer_demosaic_stream_if.slave  bus
);

  localparam int X_W   = $clog2(IMG_W);
  localparam int Y_W   = $clog2(IMG_H);
  localparam int CNT_W = $clog2(IMG_W * IMG_H + IMG_W + 2);

  localparam logic [X_W-1:0]   X_MAX     = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(IMG_W * IMG_H + IMG_W + 1);

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           cnt;
  logic                       can_load, ready_c, shift, emit, clear;
  logic [2:0][2:0][PIX_W-1:0] win;
  logic [X_W-1:0]             cx;
  logic [Y_W-1:0]             cy;
  color_t                     colour;
  logic [PIX_W-1:0]           cross_avg, diag_avg, horiz_avg, vert_avg, centre;
  logic [PIX_W-1:0]           red_c, green_c, blue_c;

  function automatic logic [PIX_W-1:0] avg4(input logic [PIX_W-1:0] a, b, c, d);
    logic [PIX_W+1:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d} + (PIX_W+2)'(2);
    return s[PIX_W+1:2];
  endfunction

  function automatic logic [PIX_W-1:0] avg2(input logic [PIX_W-1:0] a, b);
    logic [PIX_W+1:0] s;
    s = {2'b00, a} + {2'b00, b} + (PIX_W+2)'(1);
    return s[PIX_W:1];
  endfunction

  assign can_load    = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = ready_c;

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    shift     = 1'b0;
    emit      = 1'b0;
    clear     = 1'b0;
    case (state)
      FILL: begin
        ready_c = 1'b1;
        if (bus.in_valid) begin
          shift = 1'b1;
          if (cnt == FILL_LAST) state_nxt = RUN;
        end
      end
      RUN: begin
        ready_c = can_load;
        if (bus.in_valid && can_load) begin
          shift = 1'b1;
          emit  = 1'b1;
          if (cnt == RUN_LAST) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt != FLUSH_END) begin
          shift = can_load;
          emit  = can_load;
        end else if (bus.out_valid && bus.out_ready) begin
          clear     = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
    if (reset) begin
      state_nxt = FILL;
      ready_c   = 1'b0;
      shift     = 1'b0;
      emit      = 1'b0;
      clear     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  // Counts raster positions consumed, including the virtual ones stepped during FLUSH.
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (shift)     cnt <= cnt + 1'b1;
  end

  bayer_window #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_window (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .shift (shift),
    .emit  (emit),
    .pixel (bus.in_pixel),
    .win   (win),
    .cx    (cx),
    .cy    (cy)
  );

  assign colour    = site_color(CFA_PHASE, cy[0], cx[0]);
  assign centre    = win[1][1];
  assign cross_avg = avg4(win[0][1], win[2][1], win[1][2], win[1][0]);
  assign diag_avg  = avg4(win[0][0], win[0][2], win[2][0], win[2][2]);
  assign horiz_avg = avg2(win[1][0], win[1][2]);
  assign vert_avg  = avg2(win[0][1], win[2][1]);

  always_comb begin
    red_c   = centre;
    green_c = centre;
    blue_c  = centre;
    case (colour)
      RED: begin
        green_c = cross_avg;
        blue_c  = diag_avg;
      end
      BLUE: begin
        red_c   = diag_avg;
        green_c = cross_avg;
      end
      GREEN_R: begin
        red_c  = horiz_avg;
        blue_c = vert_avg;
      end
      GREEN_B: begin
        red_c  = vert_avg;
        blue_c = horiz_avg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_red   <= '0;
      bus.out_green <= '0;
      bus.out_blue  <= '0;
      bus.out_x     <= '0;
      bus.out_y     <= '0;
      bus.out_last  <= 1'b0;
    end else if (emit) begin
      bus.out_valid <= 1'b1;
      bus.out_red   <= red_c;
      bus.out_green <= green_c;
      bus.out_blue  <= blue_c;
      bus.out_x     <= cx;
      bus.out_y     <= cy;
      bus.out_last  <= (cx == X_MAX) && (cy == Y_MAX);
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bayer_demosaic_stream.sv
// Directed bench: two 4x4 demosaicers (CFA phase 0 and 3) fed the same stream,
// checked with immediate assertions against hand-computed pixels.
module tb_bayer_demosaic_stream;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic       last;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       out_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n0, n3, acc_cnt, acc6_edge, first_vld_edge, acc_at_first;

  logic [7:0] frame [16];
  pix_t       cap0 [16];
  pix_t       cap3 [16];
  logic       pat  [4];

  bayer_demosaic_stream_if #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) if0 ();
  bayer_demosaic_stream_if #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) if3 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_pixel  = in_pixel;
  assign if0.out_ready = out_ready;
  assign if3.in_valid  = in_valid;
  assign if3.in_pixel  = in_pixel;
  assign if3.out_ready = out_ready;

  bayer_demosaic_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(4), .CFA_PHASE(2'd0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  bayer_demosaic_stream #(.PIX_W(8), .IMG_W(4), .IMG_H(4), .CFA_PHASE(2'd3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (if3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Feeds frame[] and collects 16 outputs from each DUT; bp selects the ready pattern.
  task automatic run_frame(input string tag, input bit bp);
    n0 = 0; n3 = 0; acc_cnt = 0; acc6_edge = -1; first_vld_edge = -1; acc_at_first = -1;
    for (int t = 0; t < 300 && n0 < 16; t++) begin
      in_valid  = (acc_cnt < 16);
      in_pixel  = frame[(acc_cnt < 16) ? acc_cnt : 0];
      out_ready = bp ? pat[t % 4] : 1'b1;
      @(negedge clk);
      if (if0.out_valid && first_vld_edge < 0) begin
        first_vld_edge = cyc;
        acc_at_first   = acc_cnt;
      end
      if (if0.out_valid && out_ready) begin
        cap0[n0] = '{if0.out_x, if0.out_y, if0.out_last, if0.out_red, if0.out_green, if0.out_blue};
        n0++;
      end else if (if0.out_valid && bp) begin
        chk({tag, "_stall_in_ready"}, 32'(if0.in_ready), 0);
        chk({tag, "_stall_x"}, 32'(if0.out_x), n0 % 4);
        chk({tag, "_stall_y"}, 32'(if0.out_y), n0 / 4);
      end
      if (if3.out_valid && out_ready && n3 < 16) begin
        cap3[n3] = '{if3.out_x, if3.out_y, if3.out_last, if3.out_red, if3.out_green, if3.out_blue};
        n3++;
      end
      if (in_valid && if0.in_ready) begin
        acc_cnt++;
        if (acc_cnt == 6) acc6_edge = cyc + 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_count"}, n0, 16);
  endtask

  task automatic check_order(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_x"}, 32'(cap0[i].x), i % 4);
      chk({tag, "_y"}, 32'(cap0[i].y), i / 4);
      chk({tag, "_last"}, 32'(cap0[i].last), (i == 15) ? 1 : 0);
    end
  endtask

  task automatic check_uniform(input string tag, input int v, input bit both);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_r"}, 32'(cap0[i].r), v);
      chk({tag, "_g"}, 32'(cap0[i].g), v);
      chk({tag, "_b"}, 32'(cap0[i].b), v);
      if (both) begin
        chk({tag, "_p3_r"}, 32'(cap3[i].r), v);
        chk({tag, "_p3_g"}, 32'(cap3[i].g), v);
        chk({tag, "_p3_b"}, 32'(cap3[i].b), v);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pixel = 8'd0; out_ready = 1'b1;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(if0.in_ready), 0);
    chk("rst_out_valid", 32'(if0.out_valid), 0);
    chk("rst_red", 32'(if0.out_red), 0);
    chk("rst_green", 32'(if0.out_green), 0);
    chk("rst_blue", 32'(if0.out_blue), 0);
    chk("rst_last", 32'(if0.out_last), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("fill_in_ready", 32'(if0.in_ready), 1);
    chk("fill_out_valid", 32'(if0.out_valid), 0);
    @(posedge clk); #1;

    // Uniform 100
    for (int i = 0; i < 16; i++) frame[i] = 8'd100;
    run_frame("uni", 1'b0);
    chk("uni_latency", first_vld_edge - acc6_edge, 0);
    chk("uni_accepts_before_valid", acc_at_first, 6);
    check_order("uni");
    check_uniform("uni", 100, 1'b1);
    @(negedge clk);
    chk("post_frame_in_ready", 32'(if0.in_ready), 1);
    chk("post_frame_out_valid", 32'(if0.out_valid), 0);
    @(posedge clk); #1;

    // Rounding around (1,1): Red on phase 3, Blue on phase 0
    frame = '{8'd1, 8'd1, 8'd1, 8'd0,
              8'd2, 8'd9, 8'd2, 8'd0,
              8'd1, 8'd2, 8'd2, 8'd0,
              8'd0, 8'd0, 8'd0, 8'd0};
    run_frame("rnd", 1'b0);
    check_order("rnd");
    chk("rnd_p3_r", 32'(cap3[5].r), 9);
    chk("rnd_p3_g", 32'(cap3[5].g), 2);
    chk("rnd_p3_b", 32'(cap3[5].b), 1);
    chk("rnd_p0_r", 32'(cap0[5].r), 1);
    chk("rnd_p0_g", 32'(cap0[5].g), 2);
    chk("rnd_p0_b", 32'(cap0[5].b), 9);

    // Corner mirroring at (0,0) and (3,3)
    frame = '{8'd7,  8'd10, 8'd0,  8'd0,
              8'd30, 8'd50, 8'd0,  8'd0,
              8'd0,  8'd0,  8'd80, 8'd60,
              8'd0,  8'd0,  8'd20, 8'd40};
    run_frame("crn", 1'b0);
    chk("crn00_r", 32'(cap0[0].r), 7);
    chk("crn00_g", 32'(cap0[0].g), 20);
    chk("crn00_b", 32'(cap0[0].b), 50);
    chk("crn00_p3_r", 32'(cap3[0].r), 50);
    chk("crn00_p3_g", 32'(cap3[0].g), 20);
    chk("crn00_p3_b", 32'(cap3[0].b), 7);
    chk("crn33_r", 32'(cap0[15].r), 80);
    chk("crn33_g", 32'(cap0[15].g), 40);
    chk("crn33_b", 32'(cap0[15].b), 40);
    chk("crn33_last", 32'(cap0[15].last), 1);

    // Saturation
    for (int i = 0; i < 16; i++) frame[i] = 8'd255;
    run_frame("sat", 1'b0);
    check_uniform("sat", 255, 1'b1);

    // Backpressure with ready pattern 1,0,0,1
    for (int i = 0; i < 16; i++) frame[i] = 8'd77;
    run_frame("bp", 1'b1);
    check_order("bp");
    check_uniform("bp", 77, 1'b0);

    // Abort after 7 accepts, then a fresh uniform-50 frame
    acc_cnt = 0;
    for (int t = 0; t < 50 && acc_cnt < 7; t++) begin
      in_valid = 1'b1;
      in_pixel = 8'd200;
      @(negedge clk);
      if (if0.in_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("abort_accepts", acc_cnt, 7);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rst_in_ready", 32'(if0.in_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_rst_out_valid", 32'(if0.out_valid), 0);
    chk("abort_rst_red", 32'(if0.out_red), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) frame[i] = 8'd50;
    run_frame("rst", 1'b0);
    chk("rst_first_x", 32'(cap0[0].x), 0);
    chk("rst_first_y", 32'(cap0[0].y), 0);
    check_order("rst");
    check_uniform("rst", 50, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bayer_demosaic_stream.md
Name: bayer_demosaic_stream

Overview:
- Streaming, parametrised Bayer-to-RGB demosaicer for one raster frame at a time.
- Accepts one raw sample per accepted beat in raster order and emits one RGB pixel per accepted output beat.
- Holds the 3x3 neighbourhood in two internal line buffers, so the frame is never stored in memory.
- Sits between the raw-image source and the RGBA output writer; supports backpressure, edge mirroring, rounding and a selectable CFA phase.

Parameters:
PIX_W, 8, bits per raw sample and per output channel
IMG_W, 40, frame width in pixels (>=4)
IMG_H, 30, frame height in pixels (>=4)
CFA_PHASE, 0, colour at (0,0): 0=Red, 1=GreenBesideRed, 2=GreenBesideBlue, 3=Blue

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  raw sample valid
in_ready  out  1  block accepts sample this cycle
in_pixel  in  PIX_W  raw sample, raster order, frame implicit from count
out_valid  out  1  RGB pixel valid
out_ready  in  1  downstream accepts pixel
out_red  out  PIX_W  red channel
out_green  out  PIX_W  green channel
out_blue  out  PIX_W  blue channel
out_x  out  $clog2(IMG_W)  column of output pixel
out_y  out  $clog2(IMG_H)  row of output pixel
out_last  out  1  high on final pixel (IMG_W-1, IMG_H-1) of frame

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: out_valid=0, in_ready=0 for the reset cycle, out_* data=0, all counters=0, state=FILL.
- Reset mid-frame: the partial frame is discarded; the next accepted sample is (0,0).
- Handshakes: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Stall rule: while out_valid&&!out_ready, all output regs hold stable and in_ready=0.
- FSM FILL: in_ready=1, out_valid=0. Accept IMG_W+1 samples, then -> RUN.
- FSM RUN: each accepted input with raster index k produces output index k-(IMG_W+1), registered, out_valid the next cycle. After the sample at index IMG_W*IMG_H-1 is accepted -> FLUSH.
- FSM FLUSH: in_ready=0. Emit the remaining IMG_W+1 outputs, one per cycle while not stalled, using mirrored bottom rows. After the out_last transfer -> FILL for the next frame, with no idle cycle required.
- Latency: exactly one cycle from an enabling input accept, or a FLUSH step, to out_valid.
- Edge mirroring: a missing neighbour at x=-1 uses x=+1, at x=IMG_W uses x=IMG_W-2. Rows are mirrored the same way. Corners apply both mirrors.
- Colour at (x,y): phase index = CFA_PHASE ^ {y[0],x[0]}, where bit1 = row parity and bit0 = column parity.
- Red site: R=centre; G=avg4(N,S,E,W); B=avg4(NE,NW,SE,SW).
- Blue site: R and B are swapped relative to the Red site.
- GreenBesideRed site: G=centre; R=avg2(E,W); B=avg2(N,S).
- GreenBesideBlue site: G=centre; R=avg2(N,S); B=avg2(E,W).
- Arithmetic: sums are PIX_W+2 bits wide, so there is no overflow.
- Rounding: avg4=(sum+2)>>2 and avg2=(sum+1)>>1, round-half-up. Results never exceed 2^PIX_W-1.
- Line buffers: two IMG_W-deep buffers. The write pointer wraps at IMG_W. Read and write of the same address in one cycle returns the old data.
- Back-to-back frames: input for frame n+1 is not accepted until frame n's FLUSH completes.

Decomposition:
- Package bayer_pkg: color_t (Red, Blue, GreenBesideRed, GreenBesideBlue), lateral_t, vertical_t, and the CFA_PHASE encoding constants.
- Sub-module bayer_window:
  - owns the two line buffers and the 3x3 shift window;
  - applies the mirroring from the centre coordinate;
  - presents the mirrored window plus the centre x/y.
- The top level holds the FSM, counters, interpolation arithmetic and output register.

Test Plan (IMG_W=4, IMG_H=4, PIX_W=8 unless stated):
- Uniform frame, all samples 100, out_ready=1 -> 16 outputs, every channel 100, raster order, out_last only on (3,3), first out_valid 1 cycle after the 6th accept.
- Rounding: Red site (1,1), CFA_PHASE=3 so (1,1) is Red. Inputs: N=1, S=2, E=2, W=2, diagonals 1,1,1,2 -> G=2, B=1, i.e. (7+2)>>2 and (5+2)>>2.
- Saturation: all samples 255 -> all channels 255, no wrap.
- Edge mirror, corner (0,0) Red: E=(1,0)=10, S=(0,1)=30, SE=(1,1)=50 -> G=(10+10+30+30+2)>>2=20, B=50.
- Backpressure: out_ready toggles 1,0,0,1 during RUN -> outputs held stable while stalled, in_ready=0 during the stall, no pixel lost or duplicated, 16 outputs total.
- Reset asserted after 7 accepts, then a fresh uniform-50 frame -> first output is (0,0)=50/50/50, and no residue from the aborted frame appears.
